// File: rtl/ram_pkg.sv
// Shared types and the byte-lane merge used by the simple-dual-port RAM family.
// merge_be works on fixed-size containers; callers zero-extend operands and truncate the result.
package ram_pkg;

  typedef enum logic {RD_FIRST = 1'b0, WR_FIRST = 1'b1} collision_e;
  typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} clr_state_e;

  localparam int MERGE_W  = 256;
  localparam int MERGE_NB = 256;
  localparam int MERGE_BW = $clog2(MERGE_W);
  localparam int MERGE_IW = $clog2(MERGE_NB);

  // Bit i takes the new value when its lane (i / byte_w) is enabled.
  function automatic logic [MERGE_W-1:0] merge_be(
    input logic [MERGE_W-1:0]  old_w,
    input logic [MERGE_W-1:0]  new_w,
    input logic [MERGE_NB-1:0] be,
    input int                  byte_w
  );
    logic [MERGE_W-1:0] res;
    res = old_w;
    for (int i = 0; i < MERGE_W; i++) begin
      if (be[MERGE_IW'(i / byte_w)]) res[MERGE_BW'(i)] = new_w[MERGE_BW'(i)];
    end
    return res;
  endfunction

endpackage

// File: rtl/ram_clear_sweeper.sv
// Post-reset clear sweep: walks every word once writing zero, holding o_busy meanwhile.
// Provides a write override that the RAM muxes in front of its array write port.
module ram_clear_sweeper
  import ram_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  output logic             o_clr_en,
  output logic [AW-1:0]    o_clr_addr,
  output logic [WIDTH-1:0] o_clr_data,
  output logic             o_busy,
  output clr_state_e       o_state
);

  clr_state_e    state;
  logic [AW-1:0] ptr;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= CLEAR;
      ptr   <= '0;
    end else if (state == CLEAR) begin
      if (ptr == AW'(DEPTH - 1)) begin
        state <= RUN;
        ptr   <= '0;
      end else begin
        ptr <= ptr + 1'b1;
      end
    end
  end

  // No sweep writes while reset is held, so the restart always begins at word 0.
  assign o_clr_en   = (state == CLEAR) && !i_rst;
  assign o_clr_addr = ptr;
  assign o_clr_data = '0;
  assign o_busy     = (state == CLEAR);
  assign o_state    = state;

endmodule

// File: rtl/ram_sdp_be.sv
// Simple-dual-port RAM with per-byte write enables, read latency 1 or 2,
// selectable read/write collision behaviour and an optional clear-on-reset sweep.
module ram_sdp_be
  import ram_pkg::*;
#(
  parameter int         WIDTH          = 32,
  parameter int         BYTE_W         = 8,
  parameter int         DEPTH          = 256,
  parameter int         READ_LATENCY   = 1,
  parameter collision_e COLLISION      = RD_FIRST,
  parameter bit         CLEAR_ON_RESET = 1'b0,
  parameter string      FILE           = "",
  localparam int        NB             = WIDTH / BYTE_W,
  localparam int        AW             = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_wr_dv,
  input  logic [NB-1:0]    i_wr_be,
  input  logic [AW-1:0]    i_wr_addr,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  input  logic [AW-1:0]    i_rd_addr,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_rd_dv,
  output logic             o_busy
);

  if (WIDTH % BYTE_W != 0) begin : g_chk_width
    $error("ram_sdp_be: WIDTH must be a multiple of BYTE_W");
  end
  if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_chk_lat
    $error("ram_sdp_be: READ_LATENCY must be 1 or 2");
  end
  if (DEPTH < 2) begin : g_chk_depth
    $error("ram_sdp_be: DEPTH must be at least 2");
  end
  if (FILE != "" && !CLEAR_ON_RESET) begin : g_file_note
    $info("ram_sdp_be: contents image %s is applied by the memory-init flow", FILE);
  end

  logic [WIDTH-1:0] mem [DEPTH];

  logic             busy;
  logic             use_clr;
  logic             clr_en;
  logic [AW-1:0]    clr_addr;
  logic [WIDTH-1:0] clr_data;

  if (CLEAR_ON_RESET) begin : g_clear
    clr_state_e clr_state;

    ram_clear_sweeper #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (AW)
    ) u_sweeper (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .o_clr_en   (clr_en),
      .o_clr_addr (clr_addr),
      .o_clr_data (clr_data),
      .o_busy     (busy),
      .o_state    (clr_state)
    );

    assign use_clr = (clr_state == CLEAR);
  end else begin : g_no_clear
    assign busy     = 1'b0;
    assign use_clr  = 1'b0;
    assign clr_en   = 1'b0;
    assign clr_addr = '0;
    assign clr_data = '0;
  end

  assign o_busy = busy;

  // Write port: sweep override while clearing, otherwise the user port.
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic [NB-1:0]    wr_be;

  assign wr_en   = use_clr ? clr_en : (i_wr_dv && (32'(i_wr_addr) < 32'(DEPTH)));
  assign wr_addr = use_clr ? clr_addr : i_wr_addr;
  assign wr_data = use_clr ? clr_data : i_wr_data;
  assign wr_be   = use_clr ? '1 : i_wr_be;

  always_ff @(posedge i_clk) begin
    if (wr_en) begin
      for (int k = 0; k < NB; k++) begin
        if (wr_be[k]) mem[wr_addr][k*BYTE_W +: BYTE_W] <= wr_data[k*BYTE_W +: BYTE_W];
      end
    end
  end

  // Read word: out-of-range reads return zero; WR_FIRST forwards the merged write.
  logic             rd_ok;
  logic             rd_in_range;
  logic             rd_hit;
  logic [WIDTH-1:0] rd_old;
  logic [WIDTH-1:0] rd_merged;
  logic [WIDTH-1:0] rd_word;

  assign rd_ok       = i_rd_en && !busy;
  assign rd_in_range = 32'(i_rd_addr) < 32'(DEPTH);
  assign rd_old      = mem[i_rd_addr];
  assign rd_hit      = (COLLISION == WR_FIRST) && wr_en && (wr_addr == i_rd_addr);
  assign rd_merged   = WIDTH'(merge_be(MERGE_W'(rd_old), MERGE_W'(wr_data),
                                       MERGE_NB'(wr_be), BYTE_W));

  always_comb begin
    rd_word = rd_old;
    if (!rd_in_range) rd_word = '0;
    else if (rd_hit)  rd_word = rd_merged;
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic             s1_dv;
    logic [WIDTH-1:0] s1_data;

    always_ff @(posedge i_clk) begin
      if (rd_ok) s1_data <= rd_word;
    end

    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        s1_dv     <= 1'b0;
        o_rd_dv   <= 1'b0;
        o_rd_data <= '0;
      end else begin
        s1_dv   <= rd_ok;
        o_rd_dv <= s1_dv;
        if (s1_dv) o_rd_data <= s1_data;
      end
    end
  end else begin : g_lat1
    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        o_rd_dv   <= 1'b0;
        o_rd_data <= '0;
      end else begin
        o_rd_dv <= rd_ok;
        if (rd_ok) o_rd_data <= rd_word;
      end
    end
  end

endmodule

// File: tb/tb_ram_sdp_be.sv
// Directed bench for ram_sdp_be: four instances share one stimulus bus
// (RD_FIRST, WR_FIRST, latency-2 with clear sweep, 8-bit non-power-of-two depth).
module tb_ram_sdp_be;

  // Clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Shared stimulus
  logic        wr_dv   = 1'b0;
  logic [3:0]  wr_be   = 4'h0;
  logic [3:0]  wr_addr = 4'h0;
  logic [31:0] wr_data = 32'h0;
  logic        rd_en   = 1'b0;
  logic [3:0]  rd_addr = 4'h0;

  logic [31:0] rd_data_a, rd_data_b, rd_data_c;
  logic [7:0]  rd_data_d;
  logic        rd_dv_a, rd_dv_b, rd_dv_c, rd_dv_d;
  logic        busy_a, busy_b, busy_c, busy_d;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  ram_sdp_be #(.WIDTH(32), .BYTE_W(8), .DEPTH(16), .READ_LATENCY(1),
               .COLLISION(ram_pkg::RD_FIRST), .CLEAR_ON_RESET(1'b0)) u_a (
    .i_clk(clk), .i_rst(rst), .i_wr_dv(wr_dv), .i_wr_be(wr_be), .i_wr_addr(wr_addr),
    .i_wr_data(wr_data), .i_rd_en(rd_en), .i_rd_addr(rd_addr),
    .o_rd_data(rd_data_a), .o_rd_dv(rd_dv_a), .o_busy(busy_a));

  ram_sdp_be #(.WIDTH(32), .BYTE_W(8), .DEPTH(16), .READ_LATENCY(1),
               .COLLISION(ram_pkg::WR_FIRST), .CLEAR_ON_RESET(1'b0)) u_b (
    .i_clk(clk), .i_rst(rst), .i_wr_dv(wr_dv), .i_wr_be(wr_be), .i_wr_addr(wr_addr),
    .i_wr_data(wr_data), .i_rd_en(rd_en), .i_rd_addr(rd_addr),
    .o_rd_data(rd_data_b), .o_rd_dv(rd_dv_b), .o_busy(busy_b));

  ram_sdp_be #(.WIDTH(32), .BYTE_W(8), .DEPTH(16), .READ_LATENCY(2),
               .COLLISION(ram_pkg::RD_FIRST), .CLEAR_ON_RESET(1'b1)) u_c (
    .i_clk(clk), .i_rst(rst), .i_wr_dv(wr_dv), .i_wr_be(wr_be), .i_wr_addr(wr_addr),
    .i_wr_data(wr_data), .i_rd_en(rd_en), .i_rd_addr(rd_addr),
    .o_rd_data(rd_data_c), .o_rd_dv(rd_dv_c), .o_busy(busy_c));

  ram_sdp_be #(.WIDTH(8), .BYTE_W(8), .DEPTH(10), .READ_LATENCY(1),
               .COLLISION(ram_pkg::RD_FIRST), .CLEAR_ON_RESET(1'b0)) u_d (
    .i_clk(clk), .i_rst(rst), .i_wr_dv(wr_dv), .i_wr_be(wr_be[0:0]), .i_wr_addr(wr_addr),
    .i_wr_data(wr_data[7:0]), .i_rd_en(rd_en), .i_rd_addr(rd_addr),
    .o_rd_data(rd_data_d), .o_rd_dv(rd_dv_d), .o_busy(busy_d));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Driver tasks: inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    wr_dv = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
    step();
    wr_dv = 1'b0; wr_be = 4'h0;
  endtask

  task automatic rd(input logic [3:0] a);
    rd_en = 1'b1; rd_addr = a;
    step();
    rd_en = 1'b0;
  endtask

  initial begin
    int n;
    int first;
    int pulses;
    int dv_seen;

    step(); step();
    check("rst_dv_a",   32'(rd_dv_a), 0);
    check("rst_data_a", rd_data_a, 0);
    check("rst_dv_c",   32'(rd_dv_c), 0);
    check("rst_data_c", rd_data_c, 0);
    check("rst_busy_c", 32'(busy_c), 1);

    rst = 1'b0;
    n = 0;
    while (busy_c && n < 40) begin n++; step(); end
    check("busy_len_initial", n, 16);
    check("busy_a_tied", 32'(busy_a | busy_b | busy_d), 0);

    // Width-8 write then read, latency 1
    wr(4'd3, 32'h0000_00A5, 4'h1);
    check("d_dv_before_read", 32'(rd_dv_d), 0);
    rd(4'd3);
    check("d_dv_read3", 32'(rd_dv_d), 1);
    check("d_data_read3", {24'h0, rd_data_d}, 32'h0000_00A5);
    step();
    check("d_dv_idle", 32'(rd_dv_d), 0);
    check("d_data_hold", {24'h0, rd_data_d}, 32'h0000_00A5);

    // Byte-enable merge
    wr(4'd5, 32'h1122_3344, 4'hF);
    wr(4'd5, 32'hFFFF_FFFF, 4'b0101);
    rd(4'd5);
    check("a_be_merge", rd_data_a, 32'h11FF_33FF);
    check("b_be_merge", rd_data_b, 32'h11FF_33FF);
    check("d_be_merge", {24'h0, rd_data_d}, 32'h0000_00FF);

    // Collision, full and partial lanes
    wr(4'd7, 32'h0000_00AA, 4'hF);
    wr_dv = 1'b1; wr_addr = 4'd7; wr_data = 32'h0000_00BB; wr_be = 4'hF;
    rd_en = 1'b1; rd_addr = 4'd7;
    step();
    wr_dv = 1'b0; rd_en = 1'b0;
    check("a_coll_rd_first", rd_data_a, 32'h0000_00AA);
    check("b_coll_wr_first", rd_data_b, 32'h0000_00BB);
    rd(4'd7);
    check("a_after_coll", rd_data_a, 32'h0000_00BB);
    check("b_after_coll", rd_data_b, 32'h0000_00BB);
    wr_dv = 1'b1; wr_addr = 4'd7; wr_data = 32'h0000_CC00; wr_be = 4'b0010;
    rd_en = 1'b1; rd_addr = 4'd7;
    step();
    wr_dv = 1'b0; rd_en = 1'b0; wr_be = 4'h0;
    check("a_coll_partial", rd_data_a, 32'h0000_00BB);
    check("b_coll_partial", rd_data_b, 32'h0000_CCBB);
    wr(4'd7, 32'hFFFF_FFFF, 4'h0);
    rd(4'd7);
    check("a_be_zero_noop", rd_data_a, 32'h0000_CCBB);

    // Address beyond DEPTH on the 10-deep instance
    wr(4'd12, 32'h0000_0077, 4'hF);
    rd(4'd12);
    check("d_oor_dv", 32'(rd_dv_d), 1);
    check("d_oor_data", {24'h0, rd_data_d}, 0);
    check("a_addr12", rd_data_a, 32'h0000_0077);

    // Back-to-back reads, latency 2 (C) against latency 1 (A)
    for (int i = 0; i < 8; i++) wr(i[3:0], 32'(i), 4'hF);
    step(); step();
    first = -1; pulses = 0;
    for (int i = 0; i < 10; i++) begin
      rd_en = (i < 8); rd_addr = i[3:0];
      if (i < 8) exp_q.push_back(32'(i));
      step();
      if (rd_dv_c) begin
        if (first < 0) first = i;
        pulses++;
        if (exp_q.size() > 0) check("c_lat2_data", rd_data_c, exp_q.pop_front());
      end
      if (i < 8) check("a_lat1_data", rd_data_a, 32'(i));
    end
    rd_en = 1'b0;
    check("c_first_pulse", first, 1);
    check("c_pulse_count", pulses, 8);
    check("c_queue_empty", exp_q.size(), 0);

    // Fill, then drop an in-flight read with reset
    for (int i = 0; i < 16; i++) wr(i[3:0], 32'h0000_005A, 4'hF);
    rd(4'd4);
    step();
    check("c_fill_dv", 32'(rd_dv_c), 1);
    check("c_fill_data", rd_data_c, 32'h0000_005A);
    rd(4'd3);
    rst = 1'b1;
    step();
    check("c_drop_dv", 32'(rd_dv_c), 0);
    check("c_drop_data", rd_data_c, 0);
    check("a_rst_data", rd_data_a, 0);
    check("c_rst_busy", 32'(busy_c), 1);
    rst = 1'b0;

    // Reset mid-sweep at pointer 9 restarts the full sweep
    for (int i = 0; i < 9; i++) step();
    check("c_busy_mid", 32'(busy_c), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    n = 0; dv_seen = 0;
    while (busy_c && n < 40) begin
      wr_dv = (n == 0); wr_addr = 4'd2; wr_data = 32'h0000_0099; wr_be = 4'hF;
      rd_en = (n < 2); rd_addr = 4'd2;
      n++;
      step();
      if (rd_dv_c) dv_seen++;
    end
    wr_dv = 1'b0; rd_en = 1'b0; wr_be = 4'h0;
    check("busy_len_restart", n, 16);
    check("c_dv_during_busy", dv_seen, 0);

    // Readback after sweep: C all zero, A keeps its data
    pulses = 0;
    for (int i = 0; i < 17; i++) begin
      rd_en = (i < 16); rd_addr = i[3:0];
      if (i < 16) exp_q.push_back(32'h0);
      step();
      if (rd_dv_c) begin
        pulses++;
        if (exp_q.size() > 0) check("c_cleared", rd_data_c, exp_q.pop_front());
      end
      if (i < 16) check("a_readback", rd_data_a, (i == 2) ? 32'h0000_0099 : 32'h0000_005A);
    end
    rd_en = 1'b0;
    check("c_clear_pulses", pulses, 16);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
